// File: rtl/jtsdram_bank_test.sv
// SDRAM bank self-test engine: optional pattern write sweep, then read-back verify sweep.
// Define JTSDRAM_BANK_ERRLOG_EN to implement the err_cnt / first_bad error log.
module jtsdram_bank_test #(
    parameter int AW = 22,
    parameter int DW = 32,
    parameter int EW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          wr_en,
    input  logic [1:0]    pat_sel,
    input  logic [15:0]   seed,
    output logic [AW-1:0] addr,
    output logic          rd,
    output logic          wr,
    output logic [DW-1:0] din,
    input  logic          ack,
    input  logic          rdy,
    input  logic [DW-1:0] dout,
    output logic          busy,
    output logic          bad,
    output logic          done,
    output logic [EW-1:0] err_cnt,
    output logic [AW-1:0] first_bad
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]    state;
    logic          pass_wr;
    logic [1:0]    pat_q;
    logic [15:0]   seed_q;
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_nxt;
    logic [15:0]   addr16;
    logic [15:0]   pat;
    logic [DW-1:0] pat_wide;
    logic          xfer;
    logic          last;
    logic          mismatch;

    function automatic logic [15:0] lfsr_load(input logic [15:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

    generate
        if (AW >= 16) begin : g_addr_wide
            assign addr16 = addr[15:0];
        end else begin : g_addr_narrow
            assign addr16 = {{(16-AW){1'b0}}, addr};
        end
    endgenerate

    // Taps 16,14,13,11; shifted left with the feedback bit entering at bit 0
    assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    always_comb begin
        pat = seed_q;
        case (pat_q)
            2'd0:    pat = seed_q;
            2'd1:    pat = seed_q ^ addr16;
            2'd2:    pat = lfsr;
            default: pat = ~(seed_q ^ addr16);
        endcase
    end

    assign pat_wide = {(DW/16){pat}};
    assign rd       = (state == ST_REQ) && !pass_wr;
    assign wr       = (state == ST_REQ) && pass_wr;
    assign din      = wr ? pat_wide : '0;
    assign busy     = (state == ST_REQ) || (state == ST_WAIT);
    assign done     = !busy;
    assign xfer     = ((state == ST_REQ) && ack && rdy) || ((state == ST_WAIT) && rdy);
    assign last     = &addr;
    assign mismatch = xfer && !pass_wr && (dout != pat_wide);

    // Start takes priority in every state so a running sweep can be aborted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pass_wr <= 1'b0;
            pat_q   <= 2'd0;
            seed_q  <= 16'h0000;
            lfsr    <= 16'h0001;
            addr    <= '0;
            bad     <= 1'b0;
        end else if (start) begin
            state   <= ST_REQ;
            pass_wr <= wr_en;
            pat_q   <= pat_sel;
            seed_q  <= seed;
            lfsr    <= lfsr_load(seed);
            addr    <= '0;
            bad     <= 1'b0;
        end else begin
            if ((state == ST_REQ) && ack && !rdy)
                state <= ST_WAIT;
            if (xfer) begin
                if (mismatch)
                    bad <= 1'b1;
                if (last) begin
                    if (pass_wr) begin
                        pass_wr <= 1'b0;
                        addr    <= '0;
                        lfsr    <= lfsr_load(seed_q);
                        state   <= ST_REQ;
                    end else begin
                        state   <= ST_DONE;
                    end
                end else begin
                    addr  <= addr + AW'(1);
                    lfsr  <= lfsr_nxt;
                    state <= ST_REQ;
                end
            end
        end
    end

`ifdef JTSDRAM_BANK_ERRLOG_EN
    // bad is still clear on the first mismatch, which marks the address to log
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt   <= '0;
            first_bad <= '0;
        end else if (start) begin
            err_cnt   <= '0;
            first_bad <= '0;
        end else if (mismatch) begin
            if (!(&err_cnt))
                err_cnt <= err_cnt + EW'(1);
            if (!bad)
                first_bad <= addr;
        end
    end
`else
    assign err_cnt   = '0;
    assign first_bad = '0;
`endif

endmodule

// File: tb/tb_jtsdram_bank_test.sv
// Scoreboard bench for jtsdram_bank_test: expected requests are queued by the stimulus and popped by a monitor.
module tb_jtsdram_bank_test;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int EW = 16;

`ifdef JTSDRAM_BANK_ERRLOG_EN
    localparam logic [31:0] EXP_ERR = 32'd2;
    localparam logic [31:0] EXP_FB  = 32'd5;
`else
    localparam logic [31:0] EXP_ERR = 32'd0;
    localparam logic [31:0] EXP_FB  = 32'd0;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          wr_en;
    logic [1:0]    pat_sel;
    logic [15:0]   seed;
    logic [AW-1:0] addr;
    logic          rd;
    logic          wr;
    logic [DW-1:0] din;
    logic          ack;
    logic          rdy;
    logic [DW-1:0] dout;
    logic          busy;
    logic          bad;
    logic          done;
    logic [EW-1:0] err_cnt;
    logic [AW-1:0] first_bad;

    typedef struct packed {
        logic          is_wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } req_t;

    req_t        exp_q[$];
    int          tests;
    int          fails;
    logic [DW-1:0] mem [16];
    logic [15:0] corrupt;
    bit          same_cycle;
    bit          pending;
    logic [DW-1:0] resp;

    jtsdram_bank_test #(.AW(AW), .DW(DW), .EW(EW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .wr_en     (wr_en),
        .pat_sel   (pat_sel),
        .seed      (seed),
        .addr      (addr),
        .rd        (rd),
        .wr        (wr),
        .din       (din),
        .ack       (ack),
        .rdy       (rdy),
        .dout      (dout),
        .busy      (busy),
        .bad       (bad),
        .done      (done),
        .err_cnt   (err_cnt),
        .first_bad (first_bad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [15:0] lfsrStep(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    function automatic logic [15:0] patModel(input logic [1:0] ps, input logic [15:0] sd,
                                             input logic [15:0] a, input logic [15:0] lf);
        case (ps)
            2'd0:    return sd;
            2'd1:    return sd ^ a;
            2'd2:    return lf;
            default: return ~(sd ^ a);
        endcase
    endfunction

    // Queue one full sweep; reads carry no data expectation
    task automatic pushSweep(input bit is_wr, input logic [1:0] ps, input logic [15:0] sd, input int n);
        req_t e;
        logic [15:0] lf;
        lf = (sd == 16'h0) ? 16'h0001 : sd;
        for (int a = 0; a < n; a++) begin
            e.is_wr = is_wr;
            e.a     = AW'(a);
            e.d     = is_wr ? {2{patModel(ps, sd, 16'(a), lf)}} : '0;
            exp_q.push_back(e);
            lf = lfsrStep(lf);
        end
    endtask

    task automatic applyStimulus(input bit we, input logic [1:0] ps, input logic [15:0] sd);
        @(negedge clk);
        wr_en   = we;
        pat_sel = ps;
        seed    = sd;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_done"}, {31'd0, done}, 32'd1);
        checkOutput({name, "_queue_empty"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: every presented request pops one expectation
    initial begin
        req_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (rd || wr)) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_req: got rd=%0b wr=%0b addr=%0d, expected none", rd, wr, addr);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("req_is_wr", {31'd0, wr}, {31'd0, e.is_wr});
                    checkOutput("req_addr", 32'(addr), 32'(e.a));
                    if (e.is_wr)
                        checkOutput("req_din", din, e.d);
                end
            end
        end
    end

    // Memory responder: acks at once, rdy either with ack or one cycle later
    initial begin
        ack = 1'b0;
        rdy = 1'b0;
        dout = '0;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            ack = 1'b0;
            rdy = 1'b0;
            if (!rst_n) begin
                pending = 1'b0;
            end else if (pending) begin
                rdy = 1'b1;
                dout = resp;
                pending = 1'b0;
            end else if (rd || wr) begin
                ack = 1'b1;
                if (wr)
                    mem[addr] = din;
                resp = mem[addr] ^ (corrupt[addr] ? 32'h0000_0100 : 32'h0);
                if (same_cycle) begin
                    rdy = 1'b1;
                    dout = resp;
                end else begin
                    pending = 1'b1;
                end
            end
        end
    end

    initial begin
        int n;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start = 1'b0;
        wr_en = 1'b0;
        pat_sel = 2'd0;
        seed = 16'h0;
        corrupt = 16'h0;
        same_cycle = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 32'hA5A5A5A5;

        #1;
        checkOutput("rst_addr", 32'(addr), 32'd0);
        checkOutput("rst_rd", {31'd0, rd}, 32'd0);
        checkOutput("rst_wr", {31'd0, wr}, 32'd0);
        checkOutput("rst_din", din, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_bad", {31'd0, bad}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd1);
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("rst_first_bad", 32'(first_bad), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Verify-only, constant pattern
        pushSweep(1'b0, 2'd0, 16'hA5A5, 16);
        applyStimulus(1'b0, 2'd0, 16'hA5A5);
        checkOutput("start_rd", {31'd0, rd}, 32'd1);
        checkOutput("start_addr", 32'(addr), 32'd0);
        checkOutput("start_busy", {31'd0, busy}, 32'd1);
        checkOutput("start_done", {31'd0, done}, 32'd0);
        n = 0;
        while (!(rd && addr == 4'd15) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("const_reach_last", {31'd0, rd && addr == 4'd15}, 32'd1);
        @(negedge clk);
        checkOutput("const_done_before_rdy", {31'd0, done}, 32'd0);
        @(negedge clk);
        checkOutput("const_done_after_rdy", {31'd0, done}, 32'd1);
        checkOutput("const_busy_end", {31'd0, busy}, 32'd0);
        checkOutput("const_bad", {31'd0, bad}, 32'd0);
        waitDone("const", 10);

        // Write + verify, address pattern, clean memory
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        pushSweep(1'b1, 2'd1, 16'h1234, 16);
        pushSweep(1'b0, 2'd1, 16'h1234, 16);
        applyStimulus(1'b1, 2'd1, 16'h1234);
        waitDone("addr", 400);
        checkOutput("addr_bad", {31'd0, bad}, 32'd0);
        checkOutput("addr_err_cnt", 32'(err_cnt), 32'd0);

        // Same, with read corruption at addresses 5 and 9
        corrupt = 16'h0220;
        pushSweep(1'b1, 2'd1, 16'h1234, 16);
        pushSweep(1'b0, 2'd1, 16'h1234, 16);
        applyStimulus(1'b1, 2'd1, 16'h1234);
        waitDone("corrupt", 400);
        checkOutput("corrupt_bad", {31'd0, bad}, 32'd1);
        checkOutput("corrupt_err_cnt", 32'(err_cnt), EXP_ERR);
        checkOutput("corrupt_first_bad", 32'(first_bad), EXP_FB);
        corrupt = 16'h0;

        // LFSR, seed 0: first two words fixed by hand
        pushSweep(1'b1, 2'd2, 16'h0000, 16);
        exp_q[0].d = 32'h00010001;
        exp_q[1].d = 32'h00020002;
        pushSweep(1'b0, 2'd2, 16'h0000, 16);
        applyStimulus(1'b1, 2'd2, 16'h0000);
        waitDone("lfsr", 400);
        checkOutput("lfsr_bad", {31'd0, bad}, 32'd0);

        // ack+rdy together, restart at address 7 after a corrupt read at 3
        same_cycle = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = {2{~(16'h0F0F ^ 16'(i))}};
        corrupt = 16'h0008;
        pushSweep(1'b0, 2'd3, 16'h0F0F, 8);
        pushSweep(1'b0, 2'd3, 16'h0F0F, 16);
        applyStimulus(1'b0, 2'd3, 16'h0F0F);
        n = 0;
        while (!(rd && addr == 4'd7) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("restart_reach_7", {31'd0, rd && addr == 4'd7}, 32'd1);
        checkOutput("restart_bad_before", {31'd0, bad}, 32'd1);
        start = 1'b1;
        corrupt = 16'h0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("restart_addr", 32'(addr), 32'd0);
        checkOutput("restart_bad_cleared", {31'd0, bad}, 32'd0);
        checkOutput("restart_err_cleared", 32'(err_cnt), 32'd0);
        waitDone("restart", 200);
        checkOutput("restart_bad_end", {31'd0, bad}, 32'd0);
        checkOutput("restart_first_bad", 32'(first_bad), 32'd0);
        same_cycle = 1'b0;

        // Asynchronous reset while waiting for rdy
        pushSweep(1'b0, 2'd0, 16'hA5A5, 1);
        applyStimulus(1'b0, 2'd0, 16'hA5A5);
        n = 0;
        while (!(busy && !rd && !wr) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_reached", {31'd0, busy && !rd && !wr}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_rd", {31'd0, rd}, 32'd0);
        checkOutput("async_rst_done", {31'd0, done}, 32'd1);
        checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("async_rst_addr", 32'(addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("async_rst_queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
